matrix_seq_ctrl: RTL

- Command sequencer for the matrix-operation engine.
- Accepts command frames (action, size, data stream) from the host interface.
- Drives a 256x31 simple-dual-port SRAM (1 write port, 1 read port, read latency 1) with address, enable and write data, and performs the add/sub read-modify-write.
- Streams the resulting matrix back on out_valid/out_data.
- Owns the persistent matrix size and a logical transpose flag that remaps all addresses.

---
 rtl/matrix_seq_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_seq_ctrl.sv
// Command sequencer for the matrix-operation engine.
//
// Accepts command frames (action, size, data stream), drives a 256xDW
// simple-dual-port SRAM (read latency 1) to load or add/sub-modify the
// matrix, then streams the whole matrix back. A logical transpose flag
// remaps every address, so TRANSPOSE never moves data.
//
// Ports:
//   clk, rst_n            clock; synchronous active-high reset (1 = reset)
//   in_valid, in_data     command frame word valid / matrix element
//   size, action          frame header, sampled on the first frame cycle
//   mem_we/waddr/wdata    SRAM write port
//   mem_re/raddr, rdata   SRAM read port, rdata valid 1 cycle after mem_re
//   out_valid, out_data   result stream (out_data is 0 when not valid)
module matrix_seq_ctrl #(
  parameter int unsigned DW = 31,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    size,
  input  logic [2:0]    action,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StRmw, StDrain, StDump} state_e;

  state_e        state_q, state_d;
  logic [1:0]    size_q, size_d;
  logic          trans_q, trans_d;
  logic          err_q, err_d;
  logic          is_sub_q, is_sub_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic [CW-1:0] n_cur;
  logic [AW-1:0] cur_addr;

  // Element count N = D*D for size code s.
  function automatic logic [CW-1:0] n_of(input logic [1:0] s);
    case (s)
      2'd0:    return CW'(4);
      2'd1:    return CW'(16);
      2'd2:    return CW'(64);
      default: return CW'(256);
    endcase
  endfunction

  // Logical index -> physical address; transposed view swaps row and column.
  function automatic logic [AW-1:0] phys(input logic [CW-1:0] idx, input logic [1:0] s,
                                         input logic t);
    logic [AW-1:0] i, r, c, mask;
    logic [2:0]    lg;
    lg   = {1'b0, s} + 3'd1;
    i    = idx[AW-1:0];
    mask = AW'((32'd1 << lg) - 32'd1);
    r    = i >> lg;
    c    = i & mask;
    return t ? ((c << lg) | r) : i;
  endfunction

  assign n_cur    = n_of(size_q);
  assign cur_addr = phys(idx_q, size_q, trans_q);

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    trans_d     = trans_q;
    err_d       = err_q;
    is_sub_d    = is_sub_q;
    idx_d       = idx_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    rd_valid_d  = 1'b0;
    out_valid_d = rd_valid_q;
    out_data_d  = rd_valid_q ? mem_rdata : '0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    mem_re      = 1'b0;
    mem_raddr   = '0;

    unique case (state_q)
      StIdle: begin
        // Hold off new frames until the previous result stream has drained.
        if (in_valid && !rd_valid_q && !out_valid_q) begin
          idx_d = CW'(1);
          err_d = 1'b0;
          case (action)
            3'd0: begin
              size_d    = size;
              trans_d   = 1'b0;
              mem_we    = 1'b1;
              mem_waddr = '0;
              mem_wdata = in_data;
              state_d   = StLoad;
            end
            3'd1, 3'd2: begin
              // Index 0 maps to address 0 in either orientation.
              is_sub_d    = action[1];
              mem_re      = 1'b1;
              mem_raddr   = '0;
              pend_d      = 1'b1;
              pend_addr_d = '0;
              pend_data_d = in_data;
              state_d     = StRmw;
            end
            3'd3: begin
              trans_d = ~trans_q;
              state_d = StDrain;
            end
            default: begin
              err_d   = 1'b1;
              state_d = StDrain;
            end
          endcase
        end
      end
      StLoad: begin
        if (in_valid) begin
          if (idx_q < n_cur) begin
            mem_we    = 1'b1;
            mem_waddr = cur_addr;
            mem_wdata = in_data;
            idx_d     = idx_q + CW'(1);
          end
        end else begin
          idx_d   = '0;
          state_d = StDump;
        end
      end
      StRmw: begin
        // Write back the element read last cycle; a different element is
        // read this cycle, so the two ports never collide.
        if (pend_q) begin
          mem_we    = 1'b1;
          mem_waddr = pend_addr_q;
          mem_wdata = is_sub_q ? (mem_rdata - pend_data_q) : (mem_rdata + pend_data_q);
        end
        if (in_valid) begin
          if (idx_q < n_cur) begin
            mem_re      = 1'b1;
            mem_raddr   = cur_addr;
            pend_d      = 1'b1;
            pend_addr_d = cur_addr;
            pend_data_d = in_data;
            idx_d       = idx_q + CW'(1);
          end
        end else begin
          idx_d   = '0;
          state_d = StDump;
        end
      end
      StDrain: begin
        idx_d = '0;
        if (err_q) begin
          out_valid_d = 1'b1;
          out_data_d  = '0;
          state_d     = StIdle;
        end else begin
          state_d = StDump;
        end
      end
      StDump: begin
        mem_re     = 1'b1;
        mem_raddr  = cur_addr;
        rd_valid_d = 1'b1;
        idx_d      = idx_q + CW'(1);
        if (idx_q == n_cur - CW'(1)) begin
          idx_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // No memory traffic while reset is asserted.
    if (rst_n) begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_re    = 1'b0;
      mem_raddr = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= StIdle;
      size_q      <= '0;
      trans_q     <= 1'b0;
      err_q       <= 1'b0;
      is_sub_q    <= 1'b0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      rd_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      trans_q     <= trans_d;
      err_q       <= err_d;
      is_sub_q    <= is_sub_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      rd_valid_q  <= rd_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
